// File: rtl/actuator_engine_pkg.sv
// Shared types and widths for the actuator compute engine: controller handshake
// structs, FSM state encoding and default datapath widths.
package actuator_package;

  localparam int ACT_DATA_W  = 32;
  localparam int ACT_COEF_W  = 16;
  localparam int ACT_SHIFT_W = 5;

  typedef struct packed {
    logic                   clear;
    logic                   enable;
    logic                   start;
    logic [ACT_COEF_W-1:0]  coeff_r;
    logic [ACT_COEF_W-1:0]  coeff_i;
    logic [ACT_SHIFT_W-1:0] shift;
  } ctrl_engine_t;

  typedef struct packed {
    logic done;
    logic busy;
    logic sat;
  } flags_engine_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_ADD,
    ST_OUT,
    ST_DONE
  } engine_state_t;

endpackage

// File: rtl/actuator_engine_cmul.sv
// Two-stage complex multiplier: registered partial products, then combine,
// round-half-up, arithmetic shift and saturate into registered results.
module actuator_cmul
  import actuator_package::*;
#(
  parameter int DATA_W  = ACT_DATA_W,
  parameter int COEF_W  = ACT_COEF_W,
  parameter int SHIFT_W = ACT_SHIFT_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               mul_en_i,
  input  logic               add_en_i,
  input  logic [DATA_W-1:0]  ar_i,
  input  logic [DATA_W-1:0]  ai_i,
  input  logic [COEF_W-1:0]  cr_i,
  input  logic [COEF_W-1:0]  ci_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [DATA_W-1:0]  re_o,
  output logic [DATA_W-1:0]  im_o,
  output logic               sat_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int EXT_W  = PROD_W + 2;

  // Product slots: 0 = ar*cr, 1 = ai*ci, 2 = ai*cr, 3 = ar*ci
  logic [3:0][DATA_W-1:0] a_op;
  logic [3:0][COEF_W-1:0] c_op;
  logic [3:0][PROD_W-1:0] prod;

  assign a_op = {ar_i, ai_i, ai_i, ar_i};
  assign c_op = {ci_i, cr_i, ci_i, cr_i};

  for (genvar gi = 0; gi < 4; gi++) begin : g_prod
    logic [PROD_W-1:0] prod_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        prod_q <= '0;
      end else if (clear_i) begin
        prod_q <= '0;
      end else if (mul_en_i) begin
        prod_q <= {{COEF_W{a_op[gi][DATA_W-1]}}, a_op[gi]}
                * {{DATA_W{c_op[gi][COEF_W-1]}}, c_op[gi]};
      end
    end
    assign prod[gi] = prod_q;
  end

  function automatic logic signed [EXT_W-1:0] sext(input logic [PROD_W-1:0] v);
    return $signed({{2{v[PROD_W-1]}}, v});
  endfunction

  // Returns {clipped, value}; in range when all bits above the DATA_W sign agree.
  function automatic logic [DATA_W:0] clip(input logic signed [EXT_W-1:0] v);
    logic in_range;
    logic [DATA_W-1:0] res;
    in_range = (&v[EXT_W-1:DATA_W-1]) | ~(|v[EXT_W-1:DATA_W-1]);
    if (in_range)      res = v[DATA_W-1:0];
    else if (v[EXT_W-1]) res = {1'b1, {(DATA_W-1){1'b0}}};
    else               res = {1'b0, {(DATA_W-1){1'b1}}};
    return {~in_range, res};
  endfunction

  logic signed [EXT_W-1:0] rnd, sum_re, sum_im, sh_re, sh_im;
  logic [DATA_W:0] clip_re, clip_im;
  logic [DATA_W-1:0] re_q, re_d, im_q, im_d;

  always_comb begin
    rnd = '0;
    if (shift_i != '0) rnd[shift_i - 1'b1] = 1'b1;
    sum_re  = sext(prod[0]) - sext(prod[1]) + rnd;
    sum_im  = sext(prod[2]) + sext(prod[3]) + rnd;
    sh_re   = sum_re >>> shift_i;
    sh_im   = sum_im >>> shift_i;
    clip_re = clip(sh_re);
    clip_im = clip(sh_im);
    re_d    = clip_re[DATA_W-1:0];
    im_d    = clip_im[DATA_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      re_q <= '0;
      im_q <= '0;
    end else if (clear_i) begin
      re_q <= '0;
      im_q <= '0;
    end else if (add_en_i) begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign re_o  = re_q;
  assign im_o  = im_q;
  assign sat_o = add_en_i & (clip_re[DATA_W] | clip_im[DATA_W]);

endmodule

// File: rtl/actuator_engine.sv
// Actuator compute engine: start/done responder that pulls one complex sample
// from the streamer, runs it through the complex multiplier and pushes the result.
module actuator_engine
  import actuator_package::*;
#(
  parameter int DATA_W = ACT_DATA_W,
  parameter int COEF_W = ACT_COEF_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  ctrl_engine_t        ctrl_i,
  output flags_engine_t       flags_o,
  input  logic                in_r_valid_i,
  output logic                in_r_ready_o,
  input  logic [DATA_W-1:0]   in_r_data_i,
  input  logic                in_i_valid_i,
  output logic                in_i_ready_o,
  input  logic [DATA_W-1:0]   in_i_data_i,
  output logic                out_r_valid_o,
  input  logic                out_r_ready_i,
  output logic [DATA_W-1:0]   out_r_data_o,
  output logic [DATA_W/8-1:0] out_r_strb_o,
  output logic                out_i_valid_o,
  input  logic                out_i_ready_i,
  output logic [DATA_W-1:0]   out_i_data_o,
  output logic [DATA_W/8-1:0] out_i_strb_o
);

  engine_state_t state_q, state_d;
  logic held_r_q, held_i_q;
  logic [DATA_W-1:0] ar_q, ai_q;
  logic [COEF_W-1:0] cr_q, ci_q;
  logic [ACT_SHIFT_W-1:0] shift_q;
  logic out_r_valid_q, out_i_valid_q, sat_q;
  logic clr, en, accept, mul_en, add_en, cmul_sat;
  logic in_r_fire, in_i_fire, out_r_fire, out_i_fire;
  logic [DATA_W-1:0] res_r, res_i;
  logic unused_test_mode;

  assign unused_test_mode = test_mode_i;

  assign clr    = ctrl_i.clear;
  assign en     = ctrl_i.enable;
  assign accept = (state_q == ST_IDLE) & ctrl_i.start & en & ~clr;
  assign mul_en = (state_q == ST_MUL) & en & ~clr;
  assign add_en = (state_q == ST_ADD) & en & ~clr;

  // Readies come from state only, never from the output side.
  assign in_r_ready_o = (state_q == ST_LOAD) & en & ~held_r_q;
  assign in_i_ready_o = (state_q == ST_LOAD) & en & ~held_i_q;
  assign in_r_fire    = in_r_valid_i & in_r_ready_o;
  assign in_i_fire    = in_i_valid_i & in_i_ready_o;
  assign out_r_fire   = out_r_valid_q & out_r_ready_i;
  assign out_i_fire   = out_i_valid_q & out_i_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: if (en && (held_r_q || in_r_fire) && (held_i_q || in_i_fire)) state_d = ST_MUL;
      ST_MUL:  if (en) state_d = ST_ADD;
      ST_ADD:  if (en) state_d = ST_OUT;
      ST_OUT:  if (en && (!out_r_valid_q || out_r_fire) && (!out_i_valid_q || out_i_fire))
                 state_d = ST_DONE;
      ST_DONE: if (en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      held_r_q      <= 1'b0;
      held_i_q      <= 1'b0;
      ar_q          <= '0;
      ai_q          <= '0;
      cr_q          <= '0;
      ci_q          <= '0;
      shift_q       <= '0;
      out_r_valid_q <= 1'b0;
      out_i_valid_q <= 1'b0;
      sat_q         <= 1'b0;
    end else if (clr) begin
      state_q       <= state_d;
      held_r_q      <= 1'b0;
      held_i_q      <= 1'b0;
      ar_q          <= '0;
      ai_q          <= '0;
      out_r_valid_q <= 1'b0;
      out_i_valid_q <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cr_q     <= ctrl_i.coeff_r;
        ci_q     <= ctrl_i.coeff_i;
        shift_q  <= ctrl_i.shift;
        held_r_q <= 1'b0;
        held_i_q <= 1'b0;
        sat_q    <= 1'b0;
      end
      if (in_r_fire) begin
        ar_q     <= in_r_data_i;
        held_r_q <= 1'b1;
      end
      if (in_i_fire) begin
        ai_q     <= in_i_data_i;
        held_i_q <= 1'b1;
      end
      if (add_en) begin
        out_r_valid_q <= 1'b1;
        out_i_valid_q <= 1'b1;
      end else begin
        if (out_r_fire) out_r_valid_q <= 1'b0;
        if (out_i_fire) out_i_valid_q <= 1'b0;
      end
      if (cmul_sat) sat_q <= 1'b1;
    end
  end

  actuator_cmul #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .SHIFT_W(ACT_SHIFT_W)
  ) u_cmul (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clr),
    .mul_en_i(mul_en),
    .add_en_i(add_en),
    .ar_i    (ar_q),
    .ai_i    (ai_q),
    .cr_i    (cr_q),
    .ci_i    (ci_q),
    .shift_i (shift_q),
    .re_o    (res_r),
    .im_o    (res_i),
    .sat_o   (cmul_sat)
  );

  assign out_r_valid_o = out_r_valid_q;
  assign out_i_valid_o = out_i_valid_q;
  assign out_r_data_o  = res_r;
  assign out_i_data_o  = res_i;
  assign out_r_strb_o  = '1;
  assign out_i_strb_o  = '1;

  assign flags_o.done = (state_q == ST_DONE) & en & ~clr;
  assign flags_o.busy = (state_q != ST_IDLE);
  assign flags_o.sat  = sat_q;

endmodule
